// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a 1-bit serial consumer (e.g. a sequence detector).
// Latency: a word accepted at edge k shows bit 0 in cycle k+1 and its last bit in cycle k+WIDTH.
// Backpressure: in_ready = !hold_valid; one held word lets back-to-back words stream gap-free.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    parallel word offered upstream; accepted when in_valid && in_ready
//   in_ready            a word can be taken this cycle (registered, no path from in_valid)
//   ser_out/ser_valid   serial bit stream; ser_valid=0 marks IDLE_BIT filler
//   sof/eow             first / last bit of each word
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             sof,
  output logic             eow
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             active_q, active_d;
  logic             hold_valid_q, hold_valid_d;

  logic             accept;
  logic             last_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

  assign in_ready = !hold_valid_q;
  assign accept   = in_valid && in_ready;
  assign last_bit = active_q && (bit_cnt_q == LAST_CNT);
  assign cur_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Move the next bit into the output position; vacated end fills with 0.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  assign ser_valid = active_q;
  assign ser_out   = active_q ? cur_bit : IDLE_BIT;
  assign sof       = active_q && (bit_cnt_q == '0);
  assign eow       = last_bit;

  always_comb begin
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    bit_cnt_d    = bit_cnt_q;
    active_d     = active_q;
    hold_valid_d = hold_valid_q;

    if (!active_q || last_bit) begin
      // Word boundary: a held word always goes first. in_ready is low whenever
      // hold is occupied, so an accept can never collide with this transfer.
      if (hold_valid_q) begin
        shreg_d      = hold_q;
        hold_valid_d = 1'b0;
        active_d     = 1'b1;
        bit_cnt_d    = '0;
      end else if (accept) begin
        // Word can go out next cycle, so it bypasses the holding register.
        shreg_d   = in_data;
        active_d  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        active_d = 1'b0;
      end
    end else begin
      shreg_d   = shreg_shifted;
      bit_cnt_d = bit_cnt_q + CW'(1);
      if (accept) begin
        hold_d       = in_data;
        hold_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q      <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      active_q     <= 1'b0;
      hold_valid_q <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      bit_cnt_q    <= bit_cnt_d;
      active_q     <= active_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three WIDTH=4 instances (MSB-first, LSB-first,
// MSB-first with IDLE_BIT=1). Expected bits are queued at accept time and
// popped whenever the active instance shows ser_valid.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data_v [3];
  logic [2:0] in_valid_v;
  wire  [2:0] in_ready_v;
  wire  [2:0] ser_out_v;
  wire  [2:0] ser_valid_v;
  wire  [2:0] sof_v;
  wire  [2:0] eow_v;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .ser_out(ser_out_v[0]), .ser_valid(ser_valid_v[0]),
    .sof(sof_v[0]), .eow(eow_v[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .ser_out(ser_out_v[1]), .ser_valid(ser_valid_v[1]),
    .sof(sof_v[1]), .eow(eow_v[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_idle1 (
    .clk(clk), .rst(rst), .in_data(in_data_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .ser_out(ser_out_v[2]), .ser_valid(ser_valid_v[2]),
    .sof(sof_v[2]), .eow(eow_v[2]));

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } exp_t;

  exp_t       exp_q [$];
  logic [3:0] pend_q [$];
  int         errors = 0;
  int         checks = 0;

  function automatic logic idle_of(input int d);
    return (d == 2);
  endfunction

  // Expected serial order of one accepted word for instance d.
  function automatic void push_word(input int d, input logic [3:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b = (d == 1) ? w[i] : w[3-i];
      e.s = (i == 0);
      e.e = (i == 3);
      exp_q.push_back(e);
    end
  endfunction

  // Called right after a falling edge: offer the next pending word (or random
  // junk with in_valid low); an accept happens on the coming rising edge.
  task automatic drive_cycle(input int d, input int gap_pct, output bit accepted);
    accepted = 1'b0;
    if (pend_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      in_valid_v[d] = 1'b1;
      in_data_v[d]  = pend_q[0];
      if (in_ready_v[d]) begin
        push_word(d, pend_q.pop_front());
        accepted = 1'b1;
      end
    end else begin
      in_valid_v[d] = 1'b0;
      in_data_v[d]  = 4'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_v = '0;
    for (int d = 0; d < 3; d++) in_data_v[d] = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ser_out_v[d], ser_valid_v[d], in_ready_v[d], sof_v[d], eow_v[d]} !==
          {idle_of(d), 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_async dut%0d: out/vld/rdy/sof/eow=%b%b%b%b%b want %b0100",
                 d, ser_out_v[d], ser_valid_v[d], in_ready_v[d], sof_v[d], eow_v[d], idle_of(d));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({ser_out_v[d], ser_valid_v[d], in_ready_v[d], sof_v[d], eow_v[d]} !==
            {idle_of(d), 1'b0, 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL reset_idle dut%0d cyc%0d: out/vld/rdy/sof/eow=%b%b%b%b%b want %b0100",
                   d, c, ser_out_v[d], ser_valid_v[d], in_ready_v[d], sof_v[d], eow_v[d], idle_of(d));
        end
      end
    end
  endtask

  // Single word on instance d; checks bit stream, sof/eow, latency, idle fill.
  task automatic test_single(input int d, input logic [3:0] w, input string name);
    exp_t e;
    bit   acc;
    int   acc_cyc = -1, first_v = -1, last_v = -1, n_v = 0;
    logic [3:0] seen = '0;
    exp_q.delete();
    pend_q.push_back(w);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ser_valid_v[d]) begin
        n_v++;
        if (first_v < 0) first_v = c;
        last_v = c;
        seen = {seen[2:0], ser_out_v[d]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s cyc%0d: bit %b with empty scoreboard", name, c, ser_out_v[d]);
        end else begin
          e = exp_q.pop_front();
          if ({ser_out_v[d], sof_v[d], eow_v[d]} !== {e.b, e.s, e.e}) begin
            errors++;
            $display("FAIL %s cyc%0d: out/sof/eow=%b%b%b want %b%b%b", name, c,
                     ser_out_v[d], sof_v[d], eow_v[d], e.b, e.s, e.e);
          end
        end
      end else begin
        checks++;
        if ({ser_out_v[d], sof_v[d], eow_v[d]} !== {idle_of(d), 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s idle cyc%0d: out/sof/eow=%b%b%b want %b00", name, c,
                   ser_out_v[d], sof_v[d], eow_v[d], idle_of(d));
        end
      end
      drive_cycle(d, 0, acc);
      if (acc) acc_cyc = c;
    end
    checks++;
    if (first_v != acc_cyc + 1 || last_v != acc_cyc + 4 || n_v != 4) begin
      errors++;
      $display("FAIL %s_latency: first=%0d last=%0d n=%0d want first=%0d last=%0d n=4",
               name, first_v, last_v, n_v, acc_cyc + 1, acc_cyc + 4);
    end
    // Order as observed on the wire, oldest bit in the MSB of 'seen'.
    checks++;
    if (seen !== ((d == 1) ? {w[0], w[1], w[2], w[3]} : w)) begin
      errors++;
      $display("FAIL %s_order: seen=%b want %b", name, seen,
               (d == 1) ? {w[0], w[1], w[2], w[3]} : w);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bits left want 0", name, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   acc;
    int   acc_cyc = -1, first_v = -1, last_v = -1, n_v = 0;
    logic rdy_want;
    exp_q.delete();
    pend_q.push_back(4'b1011);
    pend_q.push_back(4'b0110);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ser_valid_v[0]) begin
        n_v++;
        if (first_v < 0) first_v = c;
        last_v = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b cyc%0d: bit %b with empty scoreboard", c, ser_out_v[0]);
        end else begin
          e = exp_q.pop_front();
          if ({ser_out_v[0], sof_v[0], eow_v[0]} !== {e.b, e.s, e.e}) begin
            errors++;
            $display("FAIL b2b cyc%0d: out/sof/eow=%b%b%b want %b%b%b", c,
                     ser_out_v[0], sof_v[0], eow_v[0], e.b, e.s, e.e);
          end
        end
      end
      // First word loads at acc_cyc; hold fills one cycle later and stays
      // full until word 1's last bit has gone out.
      if (acc_cyc >= 0 && c >= acc_cyc + 1 && c <= acc_cyc + 5) begin
        rdy_want = !(c >= acc_cyc + 2 && c <= acc_cyc + 4);
        checks++;
        if (in_ready_v[0] !== rdy_want) begin
          errors++;
          $display("FAIL b2b_ready cyc%0d: in_ready=%b want %b", c, in_ready_v[0], rdy_want);
        end
      end
      drive_cycle(0, 0, acc);
      if (acc && acc_cyc < 0) acc_cyc = c;
    end
    checks++;
    if (n_v != 8 || last_v - first_v != 7 || first_v != acc_cyc + 1) begin
      errors++;
      $display("FAIL b2b_contig: first=%0d last=%0d n=%0d want first=%0d n=8 contiguous",
               first_v, last_v, n_v, acc_cyc + 1);
    end
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: exp=%0d pend=%0d want 0/0", exp_q.size(), pend_q.size());
    end
  endtask

  task automatic test_reset_midword();
    bit acc;
    int acc_cyc = -1;
    exp_q.delete();
    pend_q.push_back(4'b1011);
    pend_q.push_back(4'b0110);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_cycle(0, 0, acc);
      if (acc && acc_cyc < 0) acc_cyc = c;
    end
    @(negedge clk);  // bit index 2 of word 1 on the wire, second word held
    checks++;
    if (ser_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || ser_out_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: vld=%b rdy=%b out=%b want 1 0 1",
               ser_valid_v[0], in_ready_v[0], ser_out_v[0]);
    end
    in_valid_v[0] = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({ser_out_v[0], ser_valid_v[0], in_ready_v[0], sof_v[0], eow_v[0]} !== 5'b00100) begin
      errors++;
      $display("FAIL rst_mid_async: out/vld/rdy/sof/eow=%b%b%b%b%b want 00100",
               ser_out_v[0], ser_valid_v[0], in_ready_v[0], sof_v[0], eow_v[0]);
    end
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid_v[0] !== 1'b0 || ser_out_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_remnant cyc%0d: vld=%b out=%b rdy=%b want 0 0 1",
                 c, ser_valid_v[0], ser_out_v[0], in_ready_v[0]);
      end
    end
  endtask

  task automatic test_random_stream();
    exp_t e;
    bit   acc;
    exp_q.delete();
    for (int i = 0; i < 8; i++) pend_q.push_back(4'($urandom));
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (ser_valid_v[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand cyc%0d: bit %b with empty scoreboard", c, ser_out_v[0]);
        end else begin
          e = exp_q.pop_front();
          if ({ser_out_v[0], sof_v[0], eow_v[0]} !== {e.b, e.s, e.e}) begin
            errors++;
            $display("FAIL rand cyc%0d: out/sof/eow=%b%b%b want %b%b%b", c,
                     ser_out_v[0], sof_v[0], eow_v[0], e.b, e.s, e.e);
          end
        end
      end
      drive_cycle(0, 40, acc);
    end
    in_valid_v[0] = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: exp=%0d pend=%0d want 0/0", exp_q.size(), pend_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 4'b1011, "single_msb");
    test_back_to_back();
    test_single(1, 4'b1011, "single_lsb");
    test_reset_midword();
    test_single(2, 4'b0000, "idle_one");
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
